cache_ro_assoc: RTL and testbench
=================================

Name: cache_ro_assoc

Overview:
- Read-only, set-associative data cache sitting between a consumer and backing memory.
- The consumer issues single-cycle lookups.
- Missed blocks are installed by an external agent through the fill (write) path.
- WAY=1 gives a direct-mapped cache, the cache_ro configuration.

Parameters:
- SIZE_BLOCK, 32: block (data word) width in bits.
- BIT_TOTAL, 24: address width; addressable blocks = 2^BIT_TOTAL.
- BIT_INDEX, 5: index width; sets = 2^BIT_INDEX; requires 1 <= BIT_INDEX < BIT_TOTAL.
- WAY, 1: blocks per set; any integer >= 1, power of two not required.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  request strobe, sampled on rising clk.
- wrt  in  1  1 = fill (install i_data at i_addr); 0 = read lookup.
- i_addr  in  BIT_TOTAL  block address.
- i_data  in  SIZE_BLOCK  fill data; ignored on reads.
- o_data  out  SIZE_BLOCK  read result / fill echo.
- o_success  out  1  1 = hit on read, or fill completed.

Behaviour:
- Address split:
  - index = i_addr[BIT_INDEX-1:0]
  - tag = i_addr[BIT_TOTAL-1:BIT_INDEX]
- Per set: WAY entries of {valid, tag, data}, plus a round-robin victim pointer ranging 0..WAY-1.
- Reset (rst=0, asynchronous): all valid bits cleared, all victim pointers = 0, o_data = 0, o_success = 0. Data/tag contents need not be cleared.
- Reset asserted mid-operation: any in-flight request is discarded; after release, every read misses until refilled.
- Latency: 1 cycle.
  - A request with en=1 at rising edge N has registered results on o_data/o_success right after edge N.
  - Results are valid until edge N+1.
  - No stall, no backpressure; a new request may be issued every cycle.
- en=0 at an edge: o_success <= 0, o_data holds its previous value, no state change.
- Read (en=1, wrt=0):
  - Compare tag against all valid ways of the set in parallel.
  - Hit: o_success <= 1, o_data <= matching way's data.
  - Miss: o_success <= 0, o_data <= 0.
  - Reads never modify cache state or victim pointers.
- Fill (en=1, wrt=1):
  - Tag already valid in the set: overwrite that way's data in place; victim pointer unchanged.
  - Else, if any invalid way exists: install into the lowest-numbered invalid way (valid <= 1, tag, data); pointer unchanged.
  - Else (set full): install into the way at the victim pointer, then pointer <= (pointer+1) mod WAY.
  - In all fill cases: o_success <= 1, o_data <= i_data.
- At most one way per set may hold a given tag; duplicates are forbidden.
- Hit detection is combinational over the registered array state sampled before the edge. A fill and a read cannot coincide, since there is one request per cycle.
- A read issued in the cycle after a fill to the same address hits and returns the filled data.
- Sets are fully independent; traffic to one index never affects another set.

Test Plan:
- WAY=1, BIT_INDEX=5. Fill 3=0xa, 4=0xb, 5=0xc, 0=0xe; read each → o_success=1 with 0xa, 0xb, 0xc, 0xe. Read 6 → o_success=0, o_data=0.
- WAY=1 conflict. Fill 0=0xe, fill 32=0x1; read 32 → hit 0x1; read 0 → miss, o_data=0. Then fill 64=0x2, fill 96=0x3; read 64 → miss; read 96 → hit 0x3.
- WAY=3, set 0, replacement.
  - Fill 0=0xe, 32=0x1, 64=0x2; all three reads hit.
  - Fill 96=0x3 evicts addr 0: read 0 misses, read 96 hits 0x3.
  - Refill 64=0x2 is a hit update; pointer unchanged.
  - Fill 128=0x4 evicts 32; fill 256=0x8 evicts 64.
  - Final reads: 96, 128, 256 hit; 0, 32, 64 miss.
- Reset:
  - After fills, pulse rst low between clock edges → o_success=0 and o_data=0 immediately.
  - Next reads all miss.
  - Victim pointer restarts at way 0 (following the WAY=3 sequence yields identical evictions).
- Timing / idle:
  - Back-to-back fill then read of the same address on consecutive cycles → read hits with the new data.
  - en=0 cycle → o_success=0 and o_data holds the previous value.
  - Read with wrt=0 and arbitrary i_data → array unchanged.

Source files
------------

// File: rtl/cache_ro_assoc.sv
// Read-only set-associative cache with an external fill path.
// A lookup or fill presented with en=1 is answered on o_data/o_success one
// cycle later, at a rate of one request per cycle. Each set keeps WAY entries
// of {valid, tag, data}. A fill goes to the first matching way, then to the
// lowest-numbered free way, and otherwise to the way chosen by a per-set
// round-robin victim pointer. WAY=1 gives a direct-mapped cache.
module cache_ro_assoc #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL  = 24,
  parameter int BIT_INDEX  = 5,
  parameter int WAY        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wrt,
  input  logic [BIT_TOTAL-1:0]  i_addr,
  input  logic [SIZE_BLOCK-1:0] i_data,
  output logic [SIZE_BLOCK-1:0] o_data,
  output logic                  o_success
);

  localparam int SETS  = 1 << BIT_INDEX;
  localparam int TAG_W = BIT_TOTAL - BIT_INDEX;
  localparam int PTR_W = (WAY > 1) ? $clog2(WAY) : 1;

  // Address split for the current request
  logic [BIT_INDEX-1:0] idx;
  logic [TAG_W-1:0]     tag;

  assign idx = i_addr[BIT_INDEX-1:0];
  assign tag = i_addr[BIT_TOTAL-1:BIT_INDEX];

  // Control state is reset; the tag and data storage is not
  logic [WAY-1:0]        valid_q  [SETS];
  logic [PTR_W-1:0]      victim_q [SETS];
  logic [TAG_W-1:0]      tag_q    [SETS][WAY];
  logic [SIZE_BLOCK-1:0] data_q   [SETS][WAY];

  // Lookup and placement decisions for the addressed set
  logic                  fill;
  logic                  hit;
  logic [PTR_W-1:0]      hit_way;
  logic [SIZE_BLOCK-1:0] hit_data;
  logic                  has_free;
  logic [PTR_W-1:0]      free_way;
  logic [PTR_W-1:0]      fill_way;
  logic                  evict;
  logic [PTR_W-1:0]      victim_next;

  assign fill = en & wrt;

  // Parallel tag compare against every valid way of the set
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAY; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit      = 1'b1;
        hit_way  = PTR_W'(w);
        hit_data = data_q[idx][w];
      end
    end
  end

  // Lowest-numbered invalid way; the descending scan leaves the lowest one last
  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    for (int w = WAY - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        has_free = 1'b1;
        free_way = PTR_W'(w);
      end
    end
  end

  // Pick the target way of a fill and the advanced victim pointer
  always_comb begin
    evict       = !hit && !has_free;
    fill_way    = hit ? hit_way : (has_free ? free_way : victim_q[idx]);
    victim_next = (victim_q[idx] == PTR_W'(WAY - 1)) ? '0 : victim_q[idx] + 1'b1;
  end

  // Valid bits, victim pointers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
      o_data    <= '0;
      o_success <= 1'b0;
    end else if (!en) begin
      o_success <= 1'b0;
    end else if (wrt) begin
      for (int w = 0; w < WAY; w++) begin
        if (PTR_W'(w) == fill_way) begin
          valid_q[idx][w] <= 1'b1;
        end
      end
      if (evict) begin
        victim_q[idx] <= victim_next;
      end
      o_data    <= i_data;
      o_success <= 1'b1;
    end else begin
      o_data    <= hit ? hit_data : '0;
      o_success <= hit;
    end
  end

  // Tag and data storage, written only by fills while out of reset
  always_ff @(posedge clk) begin
    if (rst && fill) begin
      for (int w = 0; w < WAY; w++) begin
        if (PTR_W'(w) == fill_way) begin
          tag_q[idx][w]  <= tag;
          data_q[idx][w] <= i_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_ro_assoc.sv
// Bench for cache_ro_assoc: a direct-mapped and a 3-way instance share inputs.
// Each is compared against a reference that holds, for each set, the resident
// blocks in insertion order. A fill of a new tag into a full set drops the
// oldest block.
module tb_cache_ro_assoc;

  localparam int TW = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wrt;
  logic [23:0] i_addr;
  logic [31:0] i_data;
  logic [31:0] d1, d3;
  logic        s1, s3;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic        e;
    logic        w;
    logic [23:0] a;
    logic [31:0] d;
  } op_t;

  // Reference state: [model][set][slot], slot 0 = oldest resident block
  int          cnt  [2][32];
  logic [TW-1:0] mtag [2][32][3];
  logic [31:0] mdat [2][32][3];
  logic        exp_s [2];
  logic [31:0] exp_d [2];

  cache_ro_assoc #(.SIZE_BLOCK(32), .BIT_TOTAL(24), .BIT_INDEX(5), .WAY(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .wrt(wrt), .i_addr(i_addr), .i_data(i_data),
    .o_data(d1), .o_success(s1));

  cache_ro_assoc #(.SIZE_BLOCK(32), .BIT_TOTAL(24), .BIT_INDEX(5), .WAY(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .wrt(wrt), .i_addr(i_addr), .i_data(i_data),
    .o_data(d3), .o_success(s3));

  always #5 clk = ~clk;

  function automatic op_t mk(input logic e, input logic w, input int a, input int d);
    op_t o;
    o.e = e;
    o.w = w;
    o.a = a[23:0];
    o.d = d;
    return o;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 32; s++) cnt[k][s] = 0;
      exp_s[k] = 1'b0;
      exp_d[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input op_t o);
    int ways;
    int s;
    int f;
    logic [TW-1:0] t;
    ways = (k == 0) ? 1 : 3;
    s = int'(o.a[4:0]);
    t = o.a[23:5];
    f = -1;
    if (!o.e) begin
      exp_s[k] = 1'b0;
    end else begin
      for (int i = 0; i < cnt[k][s]; i++) if (mtag[k][s][i] == t) f = i;
      if (!o.w) begin
        exp_s[k] = (f >= 0);
        exp_d[k] = (f >= 0) ? mdat[k][s][f] : 32'd0;
      end else begin
        if (f >= 0) begin
          mdat[k][s][f] = o.d;
        end else if (cnt[k][s] < ways) begin
          mtag[k][s][cnt[k][s]] = t;
          mdat[k][s][cnt[k][s]] = o.d;
          cnt[k][s]++;
        end else begin
          for (int i = 0; i < ways - 1; i++) begin
            mtag[k][s][i] = mtag[k][s][i+1];
            mdat[k][s][i] = mdat[k][s][i+1];
          end
          mtag[k][s][ways-1] = t;
          mdat[k][s][ways-1] = o.d;
        end
        exp_s[k] = 1'b1;
        exp_d[k] = o.d;
      end
    end
  endtask

  // Present one request between edges, advance the reference, sample after the edge
  task automatic apply(input op_t o);
    @(negedge clk);
    en     = o.e;
    wrt    = o.w;
    i_addr = o.a;
    i_data = o.d;
    model_step(0, o);
    model_step(1, o);
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
  endtask

  function automatic void replacement_ops(ref op_t q[$]);
    q.push_back(mk(1, 1, 0, 'he));
    q.push_back(mk(1, 1, 32, 'h1));
    q.push_back(mk(1, 1, 64, 'h2));
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(1, 0, 32, 0));
    q.push_back(mk(1, 0, 64, 0));
    q.push_back(mk(1, 1, 96, 'h3));
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(1, 0, 96, 0));
    q.push_back(mk(1, 1, 64, 'h2));
    q.push_back(mk(1, 1, 128, 'h4));
    q.push_back(mk(1, 1, 256, 'h8));
    q.push_back(mk(1, 0, 96, 0));
    q.push_back(mk(1, 0, 128, 0));
    q.push_back(mk(1, 0, 256, 0));
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(1, 0, 32, 0));
    q.push_back(mk(1, 0, 64, 0));
  endfunction

  task automatic test_reset();
    op_t q[$];
    #1;
    vecs++;
    if ({s1, d1} !== 33'd0) begin
      errs++;
      $display("FAIL reset_way1 got s=%b d=%h want s=0 d=0", s1, d1);
    end
    vecs++;
    if ({s3, d3} !== 33'd0) begin
      errs++;
      $display("FAIL reset_way3 got s=%b d=%h want s=0 d=0", s3, d3);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    q.push_back(mk(1, 0, 3, 'h55));
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(1, 0, 32'hffffff, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vecs++;
      if ({s1, d1} !== {exp_s[0], exp_d[0]}) begin
        errs++;
        $display("FAIL reset_read_way1 addr=%0d got s=%b d=%h want s=%b d=%h", q[i].a, s1, d1, exp_s[0], exp_d[0]);
      end
      vecs++;
      if ({s3, d3} !== {exp_s[1], exp_d[1]}) begin
        errs++;
        $display("FAIL reset_read_way3 addr=%0d got s=%b d=%h want s=%b d=%h", q[i].a, s3, d3, exp_s[1], exp_d[1]);
      end
    end
  endtask

  task automatic test_direct();
    op_t q[$];
    do_reset();
    q.push_back(mk(1, 1, 3, 'ha));
    q.push_back(mk(1, 1, 4, 'hb));
    q.push_back(mk(1, 1, 5, 'hc));
    q.push_back(mk(1, 1, 0, 'he));
    q.push_back(mk(1, 0, 3, 0));
    q.push_back(mk(1, 0, 4, 0));
    q.push_back(mk(1, 0, 5, 0));
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(1, 0, 6, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vecs++;
      if ({s1, d1} !== {exp_s[0], exp_d[0]}) begin
        errs++;
        $display("FAIL direct_way1 op=%0d got s=%b d=%h want s=%b d=%h", i, s1, d1, exp_s[0], exp_d[0]);
      end
      vecs++;
      if ({s3, d3} !== {exp_s[1], exp_d[1]}) begin
        errs++;
        $display("FAIL direct_way3 op=%0d got s=%b d=%h want s=%b d=%h", i, s3, d3, exp_s[1], exp_d[1]);
      end
    end
  endtask

  task automatic test_conflict();
    op_t q[$];
    do_reset();
    q.push_back(mk(1, 1, 0, 'he));
    q.push_back(mk(1, 1, 32, 'h1));
    q.push_back(mk(1, 0, 32, 0));
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(1, 1, 64, 'h2));
    q.push_back(mk(1, 1, 96, 'h3));
    q.push_back(mk(1, 0, 64, 0));
    q.push_back(mk(1, 0, 96, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vecs++;
      if ({s1, d1} !== {exp_s[0], exp_d[0]}) begin
        errs++;
        $display("FAIL conflict_way1 op=%0d got s=%b d=%h want s=%b d=%h", i, s1, d1, exp_s[0], exp_d[0]);
      end
      vecs++;
      if ({s3, d3} !== {exp_s[1], exp_d[1]}) begin
        errs++;
        $display("FAIL conflict_way3 op=%0d got s=%b d=%h want s=%b d=%h", i, s3, d3, exp_s[1], exp_d[1]);
      end
    end
  endtask

  task automatic test_replacement();
    op_t q[$];
    do_reset();
    replacement_ops(q);
    foreach (q[i]) begin
      apply(q[i]);
      vecs++;
      if ({s1, d1} !== {exp_s[0], exp_d[0]}) begin
        errs++;
        $display("FAIL replace_way1 op=%0d got s=%b d=%h want s=%b d=%h", i, s1, d1, exp_s[0], exp_d[0]);
      end
      vecs++;
      if ({s3, d3} !== {exp_s[1], exp_d[1]}) begin
        errs++;
        $display("FAIL replace_way3 op=%0d got s=%b d=%h want s=%b d=%h", i, s3, d3, exp_s[1], exp_d[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    op_t q[$];
    op_t pre[$];
    do_reset();
    pre.push_back(mk(1, 1, 0, 'he));
    pre.push_back(mk(1, 1, 32, 'h1));
    pre.push_back(mk(1, 1, 64, 'h2));
    pre.push_back(mk(1, 1, 96, 'h3));
    pre.push_back(mk(1, 1, 7, 'h77));
    pre.push_back(mk(1, 0, 96, 0));
    foreach (pre[i]) apply(pre[i]);
    // Pulse reset between edges while the last read result is still displayed
    #1;
    rst = 1'b0;
    #1;
    vecs++;
    if ({s1, d1} !== 33'd0) begin
      errs++;
      $display("FAIL async_rst_way1 got s=%b d=%h want s=0 d=0", s1, d1);
    end
    vecs++;
    if ({s3, d3} !== 33'd0) begin
      errs++;
      $display("FAIL async_rst_way3 got s=%b d=%h want s=0 d=0", s3, d3);
    end
    #1;
    rst = 1'b1;
    model_clear();
    q.push_back(mk(1, 0, 0, 0));
    q.push_back(mk(1, 0, 32, 0));
    q.push_back(mk(1, 0, 64, 0));
    q.push_back(mk(1, 0, 96, 0));
    q.push_back(mk(1, 0, 7, 0));
    replacement_ops(q);
    foreach (q[i]) begin
      apply(q[i]);
      vecs++;
      if ({s1, d1} !== {exp_s[0], exp_d[0]}) begin
        errs++;
        $display("FAIL after_rst_way1 op=%0d got s=%b d=%h want s=%b d=%h", i, s1, d1, exp_s[0], exp_d[0]);
      end
      vecs++;
      if ({s3, d3} !== {exp_s[1], exp_d[1]}) begin
        errs++;
        $display("FAIL after_rst_way3 op=%0d got s=%b d=%h want s=%b d=%h", i, s3, d3, exp_s[1], exp_d[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t q[$];
    do_reset();
    q.push_back(mk(1, 1, 200, 'h1234abcd));
    q.push_back(mk(1, 0, 200, 'hdeadbeef));
    q.push_back(mk(0, 1, 200, 'h0badf00d));
    q.push_back(mk(0, 0, 9, 'h11111111));
    q.push_back(mk(1, 0, 200, 'hcafef00d));
    q.push_back(mk(1, 1, 200, 'h5a5a5a5a));
    q.push_back(mk(1, 0, 200, 0));
    q.push_back(mk(1, 0, 232, 'hffffffff));
    q.push_back(mk(0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]);
      vecs++;
      if ({s1, d1} !== {exp_s[0], exp_d[0]}) begin
        errs++;
        $display("FAIL b2b_way1 op=%0d got s=%b d=%h want s=%b d=%h", i, s1, d1, exp_s[0], exp_d[0]);
      end
      vecs++;
      if ({s3, d3} !== {exp_s[1], exp_d[1]}) begin
        errs++;
        $display("FAIL b2b_way3 op=%0d got s=%b d=%h want s=%b d=%h", i, s3, d3, exp_s[1], exp_d[1]);
      end
    end
  endtask

  task automatic test_random();
    op_t o;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      o.e = ($urandom_range(0, 7) != 0);
      o.w = ($urandom_range(0, 2) == 0);
      o.a = {$urandom_range(0, 5), 5'd0} + 24'($urandom_range(0, 3));
      o.d = $urandom;
      apply(o);
      vecs++;
      if ({s1, d1} !== {exp_s[0], exp_d[0]}) begin
        errs++;
        $display("FAIL random_way1 op=%0d addr=%0d got s=%b d=%h want s=%b d=%h", i, o.a, s1, d1, exp_s[0], exp_d[0]);
      end
      vecs++;
      if ({s3, d3} !== {exp_s[1], exp_d[1]}) begin
        errs++;
        $display("FAIL random_way3 op=%0d addr=%0d got s=%b d=%h want s=%b d=%h", i, o.a, s3, d3, exp_s[1], exp_d[1]);
      end
    end
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    wrt    = 1'b0;
    i_addr = '0;
    i_data = '0;
    model_clear();
    test_reset();
    test_direct();
    test_conflict();
    test_replacement();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
